comparator_sweep_checker: RTL and testbench
===========================================

Name: comparator_sweep_checker

Overview:
- Sequential stimulus/response engine that drives the operand side of a combinational equality comparator (a, b in; aeqb out) and checks the result.
- Sweeps every {a,b} operand pair, waits a settle time, samples the comparator's equality output, and checks it against the internally computed reference (a==b).
- Reports pass/fail, error count, and the first failing vector.
- Sits beside the comparator on the board/bench as a built-in self-test.

Parameters:
- WIDTH, 2, operand width in bits; vector count N = 2^(2*WIDTH).
- SETTLE, 1, cycles operands are held before the sample cycle (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  begin sweep; sampled only in IDLE or DONE.
- a_out  output  WIDTH  operand A to comparator.
- b_out  output  WIDTH  operand B to comparator.
- dut_eq  input  1  comparator equality result.
- busy  output  1  high while sweep in progress.
- done  output  1  high from sweep completion until next start.
- pass  output  1  valid when done; 1 iff err_count==0.
- err_count  output  2*WIDTH+1  number of mismatching vectors.
- fail_valid  output  1  at least one mismatch captured.
- fail_a  output  WIDTH  A of first mismatching vector.
- fail_b  output  WIDTH  B of first mismatching vector.

Behaviour:
- Reset (async, active-high): state=IDLE; vector counter, settle counter, all outputs = 0.
- States:
  - IDLE: start -> DRIVE; clear counters, err_count, fail_*.
  - DRIVE: hold {a_out,b_out}=vector counter for SETTLE cycles; after the SETTLE-th edge -> SAMPLE.
  - SAMPLE: one cycle; compare dut_eq against (a_out==b_out).
    - Mismatch: err_count+1. If fail_valid==0, capture fail_a/fail_b and set fail_valid.
    - If counter == N-1 -> DONE, else counter+1 -> DRIVE.
  - DONE: done=1; pass=(err_count==0). start -> DRIVE with the same clears as IDLE; done/pass drop on that edge.
- Operand ordering: {a_out,b_out} = counter, so b is the LSBs. Order is 0/0, 0/1, ... up to (N-1) encoded. a_out/b_out are registered and change only on the DRIVE entry edge.
- Latency: each vector takes SETTLE+1 cycles. done is visible N*(SETTLE+1) edges after the edge that sampled start. For WIDTH=2, SETTLE=1 that is 32.
- busy = (state==DRIVE || state==SAMPLE); registered, no glitches.
- dut_eq is ignored outside SAMPLE.
- err_count cannot overflow: width holds N.
- start during DRIVE/SAMPLE is ignored. start held high continuously in DONE re-runs back-to-back.
- Reset mid-sweep aborts immediately with no partial results retained.

Decomposition:
- Shared package cmp_check_pkg holds:
  - state encodings IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3;
  - function expected_eq(a,b).
- No sub-module required. The comparator under test is instantiated externally (bench or top), not inside this block.

Test Plan:
- Ideal comparator, WIDTH=2, SETTLE=1, 1-cycle start pulse -> busy 32 cycles; operands step 0/0..3/3; done=1, pass=1, err_count=0, fail_valid=0.
- dut_eq tied 0 -> err_count=4, pass=0, fail_valid=1, fail_a=0, fail_b=0.
- dut_eq tied 1 -> err_count=12, pass=0, fail_a=0, fail_b=1.
- reset asserted 10 cycles into sweep -> all outputs 0 asynchronously, state IDLE. New start gives a clean full 32-cycle run with pass=1.
- Ideal DUT, start held high throughout -> mid-sweep start ignored. From DONE, done falls the next edge, err_count clears, a second sweep completes identically.
- SETTLE=3, dut_eq forced wrong only during DRIVE cycles -> no errors counted. done after 64 cycles, pass=1.

Source files
------------

// File: rtl/cmp_check_pkg.sv
// Shared definitions for the equality-comparator sweep checker: FSM encoding and
// the reference equality function used when sampling the external comparator.
package cmp_check_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Widest operand the reference function accepts; callers zero-extend.
    localparam int unsigned MAX_WIDTH = 16;

    function automatic logic expected_eq(input logic [MAX_WIDTH-1:0] a,
                                         input logic [MAX_WIDTH-1:0] b);
        return a == b;
    endfunction

endpackage

// File: rtl/comparator_sweep_checker_if.sv
// Signal bundle between the sweep checker and its environment (control, operands,
// comparator response and result reporting).
interface comparator_sweep_checker_if #(
    parameter int unsigned WIDTH = 2
);

    logic               start;
    logic [WIDTH-1:0]   a_out;
    logic [WIDTH-1:0]   b_out;
    logic               dut_eq;
    logic               busy;
    logic               done;
    logic               pass;
    logic [2*WIDTH:0]   err_count;
    logic               fail_valid;
    logic [WIDTH-1:0]   fail_a;
    logic [WIDTH-1:0]   fail_b;

    modport master (
        input  start,
        input  dut_eq,
        output a_out,
        output b_out,
        output busy,
        output done,
        output pass,
        output err_count,
        output fail_valid,
        output fail_a,
        output fail_b
    );

    modport slave (
        output start,
        output dut_eq,
        input  a_out,
        input  b_out,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  fail_valid,
        input  fail_a,
        input  fail_b
    );

endinterface

// File: rtl/comparator_sweep_checker.sv
// Built-in self-test for an external equality comparator: sweeps every {a,b} pair,
// samples the comparator after a settle time and records errors and the first failure.
module comparator_sweep_checker
    import cmp_check_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned SETTLE = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    comparator_sweep_checker_if.master  bus
);

    localparam int unsigned VEC_W    = 2 * WIDTH;
    localparam int unsigned SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VEC_W-1:0]    LAST_VEC   = '1;
    localparam logic [SETTLE_W-1:0] SETTLE_END = SETTLE_W'(SETTLE - 1);

    state_t              state_q;
    logic [VEC_W-1:0]    vec_q;
    logic [SETTLE_W-1:0] settle_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [VEC_W:0]      err_q;
    logic                fail_valid_q;
    logic [WIDTH-1:0]    fail_a_q;
    logic [WIDTH-1:0]    fail_b_q;

    logic [WIDTH-1:0]    vec_a;
    logic [WIDTH-1:0]    vec_b;
    logic                mismatch;

    // Operand B occupies the LSBs so the sweep order is 0/0, 0/1, ... .
    assign vec_a = vec_q[VEC_W-1:WIDTH];
    assign vec_b = vec_q[WIDTH-1:0];

    assign mismatch = (state_q == SAMPLE) &&
                      (bus.dut_eq != expected_eq(MAX_WIDTH'(vec_a), MAX_WIDTH'(vec_b)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_a_q     <= '0;
            fail_b_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q      <= DRIVE;
                        vec_q        <= '0;
                        settle_q     <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        fail_a_q     <= '0;
                        fail_b_q     <= '0;
                    end
                end
                DRIVE: begin
                    if (settle_q == SETTLE_END) begin
                        state_q  <= SAMPLE;
                        settle_q <= '0;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            fail_a_q     <= vec_a;
                            fail_b_q     <= vec_b;
                        end
                    end
                    if (vec_q == LAST_VEC) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        // Fold in the final vector's result, which err_q has not seen yet.
                        pass_q  <= (err_q == '0) && !mismatch;
                    end else begin
                        state_q <= DRIVE;
                        vec_q   <= vec_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.a_out      = vec_a;
    assign bus.b_out      = vec_b;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.fail_a     = fail_a_q;
    assign bus.fail_b     = fail_b_q;

endmodule

// File: tb/tb_comparator_sweep_checker.sv
// Bench for comparator_sweep_checker: two instances (SETTLE=1 and SETTLE=3) share the
// stimulus and are checked every cycle against a sweep model plus literal expectations.
module tb_comparator_sweep_checker;

    localparam int N = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   mode = 0;

    int checks = 0;
    int fails  = 0;

    int sv[2] = '{1, 3};
    int mk[2], merr[2], mfa[2], mfb[2], ma[2], mb[2];
    bit mrun[2], mdone[2], mpass[2], mfv[2];
    bit cur_sample[2];

    always #5 clk = ~clk;

    comparator_sweep_checker_if #(.WIDTH(2)) bus1 ();
    comparator_sweep_checker_if #(.WIDTH(2)) bus3 ();

    comparator_sweep_checker #(.WIDTH(2), .SETTLE(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    comparator_sweep_checker #(.WIDTH(2), .SETTLE(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3)
    );

    // Comparator stand-in: 0 ideal, 1 tied low, 2 tied high, 3 wrong outside sample.
    function automatic bit tb_eq(input int m, input int a, input int b, input bit s);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return s ? (a == b) : (a != b);
            default: return a == b;
        endcase
    endfunction

    assign bus1.start  = start;
    assign bus3.start  = start;
    assign bus1.dut_eq = tb_eq(mode, int'(bus1.a_out), int'(bus1.b_out), cur_sample[0]);
    assign bus3.dut_eq = tb_eq(mode, int'(bus3.a_out), int'(bus3.b_out), cur_sample[1]);

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_clear(input int d);
        mrun[d] = 0; mdone[d] = 0; mpass[d] = 0; mfv[d] = 0;
        mk[d] = 0; merr[d] = 0; mfa[d] = 0; mfb[d] = 0; ma[d] = 0; mb[d] = 0;
        cur_sample[d] = 0;
    endtask

    // Advance the model across the coming edge; k counts cycles since the start edge.
    task automatic model_step(input int d, input bit st);
        int per;
        int idx;
        bit e;
        per = sv[d] + 1;
        cur_sample[d] = mrun[d] && (mk[d] % per == per - 1);
        if (mrun[d]) begin
            if (cur_sample[d]) begin
                e = tb_eq(mode, ma[d], mb[d], 1'b1);
                if (e != (ma[d] == mb[d])) begin
                    merr[d]++;
                    if (!mfv[d]) begin
                        mfv[d] = 1; mfa[d] = ma[d]; mfb[d] = mb[d];
                    end
                end
            end
            mk[d]++;
            if (mk[d] == N * per) begin
                mrun[d] = 0; mdone[d] = 1; mpass[d] = (merr[d] == 0);
            end else begin
                idx = mk[d] / per;
                ma[d] = idx / 4;
                mb[d] = idx % 4;
            end
        end else if (st) begin
            model_clear(d);
            mrun[d] = 1;
        end
    endtask

    task automatic cmp_one(input int d, input logic busy, input logic done, input logic pass,
                           input logic [4:0] err, input logic fv, input logic [1:0] fa,
                           input logic [1:0] fb, input logic [1:0] a, input logic [1:0] b);
        string p;
        p = (d == 0) ? "s1" : "s3";
        chk($sformatf("%s_busy", p), int'(busy), int'(mrun[d]));
        chk($sformatf("%s_done", p), int'(done), int'(mdone[d]));
        chk($sformatf("%s_pass", p), int'(pass), int'(mpass[d]));
        chk($sformatf("%s_err_count", p), int'(err), merr[d]);
        chk($sformatf("%s_fail_valid", p), int'(fv), int'(mfv[d]));
        chk($sformatf("%s_fail_a", p), int'(fa), mfa[d]);
        chk($sformatf("%s_fail_b", p), int'(fb), mfb[d]);
        chk($sformatf("%s_a_out", p), int'(a), ma[d]);
        chk($sformatf("%s_b_out", p), int'(b), mb[d]);
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(negedge clk);
            if (reset) begin
                model_clear(0);
                model_clear(1);
            end else begin
                cmp_one(0, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_valid,
                        bus1.fail_a, bus1.fail_b, bus1.a_out, bus1.b_out);
                cmp_one(1, bus3.busy, bus3.done, bus3.pass, bus3.err_count, bus3.fail_valid,
                        bus3.fail_a, bus3.fail_b, bus3.a_out, bus3.b_out);
                model_step(0, start);
                model_step(1, start);
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_done(output int f1, output int f3);
        f1 = -1;
        f3 = -1;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk); #2;
            if (bus1.done && f1 < 0) f1 = k;
            if (bus3.done && f3 < 0) f3 = k;
            if (f1 >= 0 && f3 >= 0) break;
        end
        if (f1 < 0 || f3 < 0) begin
            fails++;
            checks++;
            $display("FAIL done_timeout: got s1=%0d s3=%0d expected both >= 0", f1, f3);
        end
    endtask

    task automatic expect_result(input string tag, input int err, input int pass,
                                 input int fv, input int fa, input int fb);
        chk({tag, "_err_count"}, int'(bus1.err_count), err);
        chk({tag, "_pass"}, int'(bus1.pass), pass);
        chk({tag, "_fail_valid"}, int'(bus1.fail_valid), fv);
        chk({tag, "_fail_a"}, int'(bus1.fail_a), fa);
        chk({tag, "_fail_b"}, int'(bus1.fail_b), fb);
        chk({tag, "_s3_err_count"}, int'(bus3.err_count), err);
    endtask

    initial begin
        int f1, f3, pulses1, pulses3;

        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        chk("reset_busy", int'(bus1.busy), 0);
        chk("reset_done", int'(bus1.done), 0);

        // Ideal comparator.
        mode = 0;
        pulse_start();
        wait_done(f1, f3);
        chk("ideal_s1_latency", f1, 32);
        chk("ideal_s3_latency", f3, 64);
        expect_result("ideal", 0, 1, 0, 0, 0);

        // Comparator output stuck low: only the four a==b vectors fail.
        mode = 1;
        pulse_start();
        wait_done(f1, f3);
        expect_result("tie0", 4, 0, 1, 0, 0);

        // Stuck high: the twelve a!=b vectors fail, first is 0/1.
        mode = 2;
        pulse_start();
        wait_done(f1, f3);
        expect_result("tie1", 12, 0, 1, 0, 1);

        // Asynchronous abort mid-sweep, then a clean rerun.
        mode = 0;
        pulse_start();
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", int'(bus1.busy), 0);
        chk("abort_a_out", int'(bus1.a_out), 0);
        chk("abort_b_out", int'(bus1.b_out), 0);
        chk("abort_err_count", int'(bus1.err_count), 0);
        chk("abort_s3_busy", int'(bus3.busy), 0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        pulse_start();
        wait_done(f1, f3);
        chk("rerun_s1_latency", f1, 32);
        expect_result("rerun", 0, 1, 0, 0, 0);

        // Start held high: back-to-back sweeps with a single DONE cycle between them.
        pulses1 = 0;
        pulses3 = 0;
        @(posedge clk); #2 start = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk); #2;
            if (bus1.done) pulses1++;
            if (bus3.done) pulses3++;
        end
        start = 1'b0;
        chk("held_s1_done_pulses", pulses1, 3);
        chk("held_s3_done_pulses", pulses3, 1);
        wait_done(f1, f3);
        expect_result("held", 0, 1, 0, 0, 0);

        // Comparator wrong only while operands settle: must not be counted.
        mode = 3;
        pulse_start();
        wait_done(f1, f3);
        chk("settle_s3_latency", f3, 64);
        chk("settle_s3_pass", int'(bus3.pass), 1);
        expect_result("settle", 0, 1, 0, 0, 0);

        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
